// File: rtl/sgd_a_rd_credit_issuer_pkg.sv
// Shared SGD bank/engine geometry and helpers used by the A-read credit issuer.
package sgd_a_rd_credit_issuer_pkg;

    localparam int BIT_WIDTH_OF_BANK = 3;
    localparam int NUM_OF_BANKS      = 1 << BIT_WIDTH_OF_BANK;
    localparam int ENGINE_NUM_WIDTH  = 6;
    localparam int CHUNK_SHIFT       = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH;

    // Number of chunks needed to cover `dim` features, rounded up; 33-bit sum avoids overflow.
    function automatic logic [31:0] ceil_chunks(input logic [31:0] dim);
        logic [32:0] sum;
        sum = {1'b0, dim} + 33'((1 << CHUNK_SHIFT) - 1);
        return sum[32:CHUNK_SHIFT] == '0 ? 32'd0 : 32'(sum >> CHUNK_SHIFT);
    endfunction

endpackage

// File: rtl/sgd_credit_window.sv
// Classifies the outstanding model-writer credit window into grant / error.
module sgd_credit_window (
    input  logic [7:0] credit,
    input  logic [7:0] consumed,
    output logic       grant,
    output logic       error
);

    logic [7:0] avail;

    // 8-bit subtraction wraps naturally, so a 255->0 credit step is just more credit.
    assign avail = credit - consumed;
    assign error = avail[7];
    assign grant = !avail[7] && (avail != 8'd0);

endmodule

// File: rtl/sgd_a_rd_credit_issuer.sv
// Issues per-group chunk read descriptors for the A matrix, paced by writer credit.
module sgd_a_rd_credit_issuer
    import sgd_a_rd_credit_issuer_pkg::*;
#(
    parameter int CHUNK_BITS = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  started,
    input  logic [31:0]           dimension,
    input  logic [31:0]           number_of_samples,
    input  logic [31:0]           number_of_epochs,
    input  logic [7:0]            x_wr_credit_counter,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [31:0]           rd_req_group,
    output logic [CHUNK_BITS-1:0] rd_req_chunk,
    output logic                  rd_req_last,
    output logic                  a_rd_done,
    output logic                  a_rd_error,
    output logic [31:0]           state_counters_a_rd
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_START       = 3'd1;
    localparam logic [2:0] S_EPOCH       = 3'd2;
    localparam logic [2:0] S_WAIT_CREDIT = 3'd3;
    localparam logic [2:0] S_ISSUE       = 3'd4;
    localparam logic [2:0] S_DONE        = 3'd5;

    logic [2:0]            state;
    logic                  started_r, started_r2;
    logic [31:0]           dimension_r, samples_r, epochs_r, chunks_r;
    logic [9:0]            epoch_index;
    logic [31:0]           group_index;
    logic [CHUNK_BITS-1:0] chunk;
    logic [7:0]            consumed;
    logic                  credit_grant, credit_error;
    logic                  last_chunk;

    sgd_credit_window u_credit_window (
        .credit   (x_wr_credit_counter),
        .consumed (consumed),
        .grant    (credit_grant),
        .error    (credit_error)
    );

    assign last_chunk          = (32'(chunk) == chunks_r - 32'd1);
    assign rd_req_valid        = (state == S_ISSUE);
    assign rd_req_group        = group_index;
    assign rd_req_chunk        = chunk;
    assign rd_req_last         = rd_req_valid && last_chunk;
    assign state_counters_a_rd = {rd_req_valid, state, group_index[19:0], epoch_index[7:0]};

    // Configuration is re-sampled every cycle; chunks lags dimension by one more stage.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            started_r   <= 1'b0;
            started_r2  <= 1'b0;
            dimension_r <= '0;
            samples_r   <= '0;
            epochs_r    <= '0;
            chunks_r    <= '0;
        end else begin
            started_r   <= started;
            started_r2  <= started_r;
            dimension_r <= dimension;
            samples_r   <= number_of_samples;
            epochs_r    <= number_of_epochs;
            chunks_r    <= ceil_chunks(dimension_r);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            epoch_index <= '0;
            group_index <= '0;
            chunk       <= '0;
            consumed    <= '0;
            a_rd_done   <= 1'b0;
            a_rd_error  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (started_r2) state <= S_START;
                end
                S_START: begin
                    epoch_index <= '0;
                    group_index <= '0;
                    consumed    <= '0;
                    if (chunks_r == 32'd0) begin
                        a_rd_error <= 1'b1;
                        a_rd_done  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_EPOCH;
                    end
                end
                S_EPOCH: begin
                    group_index <= '0;
                    if (epoch_index == epochs_r[9:0]) begin
                        a_rd_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_WAIT_CREDIT;
                    end
                end
                S_WAIT_CREDIT: begin
                    if (group_index == samples_r) begin
                        epoch_index <= epoch_index + 10'd1;
                        state       <= S_EPOCH;
                    end else if (credit_error) begin
                        a_rd_error <= 1'b1;
                        a_rd_done  <= 1'b1;
                        state      <= S_DONE;
                    end else if (credit_grant) begin
                        chunk <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rd_req_ready) begin
                        if (last_chunk) begin
                            group_index <= group_index + 32'(NUM_OF_BANKS);
                            consumed    <= consumed + 8'd1;
                            state       <= S_WAIT_CREDIT;
                        end else begin
                            chunk <= chunk + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    a_rd_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sgd_a_rd_credit_issuer.sv
// Scoreboard bench for sgd_a_rd_credit_issuer: directed runs, monitor checks every accept.
module tb_sgd_a_rd_credit_issuer;

    localparam int CB = 12;

    typedef struct packed {
        logic [31:0]   group;
        logic [CB-1:0] chunk;
        logic          last;
    } desc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          started = 1'b0;
    logic [31:0]   dimension = '0, number_of_samples = '0, number_of_epochs = '0;
    logic [7:0]    credit = '0;
    logic          rd_req_valid, rdy = 1'b1;
    logic [31:0]   rd_req_group;
    logic [CB-1:0] rd_req_chunk;
    logic          rd_req_last, a_rd_done, a_rd_error;
    logic [31:0]   state_counters_a_rd;

    int    n_pass = 0, n_total = 0;
    int    grp_cnt = 0, acc_cnt = 0, valid_cnt = 0;
    desc_t exp_q[$];

    sgd_a_rd_credit_issuer #(.CHUNK_BITS(CB)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .started             (started),
        .dimension           (dimension),
        .number_of_samples   (number_of_samples),
        .number_of_epochs    (number_of_epochs),
        .x_wr_credit_counter (credit),
        .rd_req_valid        (rd_req_valid),
        .rd_req_ready        (rdy),
        .rd_req_group        (rd_req_group),
        .rd_req_chunk        (rd_req_chunk),
        .rd_req_last         (rd_req_last),
        .a_rd_done           (a_rd_done),
        .a_rd_error          (a_rd_error),
        .state_counters_a_rd (state_counters_a_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares accepted descriptors against the queue and checks hold-while-stalled.
    initial begin : monitor
        logic  hold_pending;
        desc_t hold_val, cur, e;
        logic  have_exp;
        hold_pending = 1'b0;
        hold_val     = '0;
        forever begin
            @(negedge clk);
            cur = '{group: rd_req_group, chunk: rd_req_chunk, last: rd_req_last};
            if (!rst_n) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", 64'(rd_req_valid), 64'd1);
                    check("hold_payload", 64'(cur), 64'(hold_val));
                end
                hold_pending = 1'b0;
                if (rd_req_valid) begin
                    valid_cnt++;
                    if (rdy) begin
                        have_exp = (exp_q.size() != 0);
                        check("desc_expected", 64'(have_exp), 64'd1);
                        if (have_exp) begin
                            e = exp_q.pop_front();
                            check("desc", 64'(cur), 64'(e));
                        end
                        acc_cnt++;
                        if (rd_req_last) grp_cnt++;
                    end else begin
                        hold_pending = 1'b1;
                        hold_val     = cur;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_group(input int g, input int nchunks);
        for (int c = 0; c < nchunks; c++)
            exp_q.push_back('{group: 32'(g), chunk: CB'(c), last: (c == nchunks - 1)});
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        started = 1'b0;
        rdy     = 1'b1;
        credit  = 8'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        grp_cnt   = 0;
        acc_cnt   = 0;
        valid_cnt = 0;
    endtask

    task automatic start_run(input int dim, input int samples, input int epochs, input logic [7:0] cr);
        dimension         = 32'(dim);
        number_of_samples = 32'(samples);
        number_of_epochs  = 32'(epochs);
        credit            = cr;
        started           = 1'b1;
    endtask

    task automatic wait_groups(input string name, input int n, input int budget);
        int k = 0;
        while (grp_cnt < n && k < budget) begin tick(); k++; end
        check(name, 64'(grp_cnt), 64'(n));
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!a_rd_done && k < budget) begin tick(); k++; end
        check(name, 64'(a_rd_done), 64'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!rd_req_valid && k < budget) begin tick(); k++; end
        check(name, 64'(rd_req_valid), 64'd1);
    endtask

    initial begin : stimulus
        // Reset state, observed while rst_n is held low.
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_valid", 64'(rd_req_valid), 64'd0);
        check("rst_done", 64'(a_rd_done), 64'd0);
        check("rst_error", 64'(a_rd_error), 64'd0);
        check("rst_debug", 64'(state_counters_a_rd), 64'd0);
        check("rst_payload", 64'({rd_req_group, rd_req_chunk, rd_req_last}), 64'd0);

        // Two chunks per group, two groups, credit 2 up front.
        do_reset();
        push_group(0, 2);
        push_group(8, 2);
        start_run(1024, 16, 1, 8'd2);
        wait_done("basic_done", 200);
        check("basic_groups", 64'(grp_cnt), 64'd2);
        check("basic_error", 64'(a_rd_error), 64'd0);
        check("basic_debug", 64'(state_counters_a_rd), 64'h5000_0001);
        check("basic_q_empty", 64'(exp_q.size()), 64'd0);

        // No credit: nothing issued; one credit: exactly one group, then stall.
        do_reset();
        start_run(1024, 16, 1, 8'd0);
        repeat (100) tick();
        check("nocredit_valid", 64'(valid_cnt), 64'd0);
        push_group(0, 2);
        credit = 8'd1;
        wait_groups("onecredit_groups", 1, 50);
        repeat (50) tick();
        check("stall_valid", 64'(valid_cnt), 64'd2);
        check("stall_done", 64'(a_rd_done), 64'd0);
        check("stall_q_empty", 64'(exp_q.size()), 64'd0);

        // Walk consumed to 254, then step credit 254->255->0 across the wrap.
        do_reset();
        for (int g = 0; g < 256; g++) push_group(g * 8, 1);
        start_run(512, 2048, 1, 8'd0);
        credit = 8'd100;
        wait_groups("wrap_g100", 100, 1000);
        credit = 8'd200;
        wait_groups("wrap_g200", 200, 1000);
        credit = 8'd254;
        wait_groups("wrap_g254", 254, 1000);
        repeat (20) tick();
        check("wrap_stall254", 64'(grp_cnt), 64'd254);
        credit = 8'd255;
        wait_groups("wrap_g255", 255, 100);
        credit = 8'd0;
        wait_groups("wrap_g256", 256, 100);
        wait_done("wrap_done", 100);
        check("wrap_error", 64'(a_rd_error), 64'd0);
        check("wrap_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure mid-group: three chunks, ready low for 5 cycles after the first.
        do_reset();
        push_group(0, 3);
        start_run(1536, 8, 1, 8'd1);
        wait_valid("bp_valid", 50);
        tick();
        rdy = 1'b0;
        repeat (5) tick();
        check("bp_acc_during_stall", 64'(acc_cnt), 64'd1);
        rdy = 1'b1;
        wait_done("bp_done", 100);
        check("bp_accepted", 64'(acc_cnt), 64'd3);
        check("bp_q_empty", 64'(exp_q.size()), 64'd0);

        // Zero dimension is a configuration error.
        do_reset();
        start_run(0, 16, 1, 8'd1);
        wait_done("dim0_done", 50);
        check("dim0_error", 64'(a_rd_error), 64'd1);
        check("dim0_valid", 64'(valid_cnt), 64'd0);

        // Zero epochs finishes cleanly without issuing.
        do_reset();
        start_run(1024, 16, 0, 8'd1);
        wait_done("ep0_done", 50);
        check("ep0_error", 64'(a_rd_error), 64'd0);
        check("ep0_valid", 64'(valid_cnt), 64'd0);

        // Credit jump of 200 is out of window.
        do_reset();
        start_run(1024, 16, 1, 8'd0);
        repeat (10) tick();
        credit = 8'd200;
        wait_done("jump_done", 50);
        check("jump_error", 64'(a_rd_error), 64'd1);
        check("jump_valid", 64'(valid_cnt), 64'd0);

        // Reset during ISSUE drops valid; run restarts while started stays high.
        do_reset();
        rdy = 1'b0;
        start_run(1024, 16, 1, 8'd1);
        wait_valid("rstmid_valid", 50);
        rst_n = 1'b0;
        tick();
        check("rstmid_dropped", 64'(rd_req_valid), 64'd0);
        rst_n = 1'b1;
        rdy   = 1'b1;
        push_group(0, 2);
        wait_groups("rstmid_restart", 1, 50);
        check("rstmid_q_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
